// File: rtl/if_stage_pc.sv
// Fetch-stage program counter with next-PC selection and the IF/ID pipeline register.
// Also provides a free-running count of fetches retired into D for debug visibility.
module if_stage_pc #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr_d,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] pc4_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  logic [31:0] r_pc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_npc_raw;
  logic [31:0] w_npc;

  // Instruction fetches are word aligned; low address bits are dropped silently.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // j/jal region comes from the PC+4 of the jump itself, which sits in D.
  always_comb begin
    w_npc_raw = pc4_in;
    case (npc_sel)
      NPC_SEQ: w_npc_raw = pc4_in;
      NPC_BR:  w_npc_raw = br_target;
      NPC_J:   w_npc_raw = {r_pc4_d[31:28], j_index, 2'b00};
      NPC_JR:  w_npc_raw = jr_target;
      default: w_npc_raw = pc4_in;
    endcase
    w_npc = word_align(w_npc_raw);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_instr_d   <= '0;
      r_pc_d      <= '0;
      r_pc4_d     <= '0;
      r_valid_d   <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (!stall) begin
      r_pc <= w_npc;
      if (clr_d) begin
        r_instr_d <= '0;
        r_pc_d    <= '0;
        r_pc4_d   <= '0;
        r_valid_d <= 1'b0;
      end else begin
        r_instr_d   <= instr_in;
        r_pc_d      <= r_pc;
        r_pc4_d     <= pc4_in;
        r_valid_d   <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign pc_out    = r_pc;
  assign instr_d   = r_instr_d;
  assign pc_d      = r_pc_d;
  assign pc4_d     = r_pc4_d;
  assign valid_d   = r_valid_d;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage_pc.sv
// Bench for if_stage_pc: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the fetch stage.
module tb_if_stage_pc;

  localparam logic [31:0] RESET_PC = 32'h00003000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        clr_d;
  logic [1:0]  npc_sel;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] pc4_in;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic [31:0] fetch_cnt;

  int n_chk;
  int n_bad;

  // Expected architectural state of F and D.
  logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d, m_cnt;
  logic        m_valid;

  if_stage_pc #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .clr_d(clr_d), .npc_sel(npc_sel),
    .br_target(br_target), .j_index(j_index), .jr_target(jr_target),
    .pc4_in(pc4_in), .instr_in(instr_in), .pc_out(pc_out), .instr_d(instr_d),
    .pc_d(pc_d), .pc4_d(pc4_d), .valid_d(valid_d), .fetch_cnt(fetch_cnt)
  );

  // External +4 adder.
  assign pc4_in = pc_out + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("instr_d", instr_d, m_instr_d);
    chk("pc_d", pc_d, m_pc_d);
    chk("pc4_d", pc4_d, m_pc4_d);
    chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  // Apply one cycle of inputs, advance the model by the spec's rules, clock, check.
  task automatic cyc(input logic rst, input logic stl, input logic clr, input logic [1:0] sel,
                     input logic [31:0] br, input logic [25:0] ji, input logic [31:0] jr,
                     input logic [31:0] ins);
    logic [31:0] target;
    reset = rst; stall = stl; clr_d = clr; npc_sel = sel;
    br_target = br; j_index = ji; jr_target = jr; instr_in = ins;
    if (rst) begin
      m_pc = RESET_PC; m_instr_d = 0; m_pc_d = 0; m_pc4_d = 0; m_valid = 0; m_cnt = 0;
    end else if (!stl) begin
      if (sel == 2'd0)      target = m_pc + 32'd4;
      else if (sel == 2'd1) target = br;
      else if (sel == 2'd2) target = (m_pc4_d & 32'hF000_0000) + ({6'd0, ji} * 4);
      else                  target = jr;
      target = target - (target % 4);
      if (clr) begin
        m_instr_d = 0; m_pc_d = 0; m_pc4_d = 0; m_valid = 0;
      end else begin
        m_instr_d = ins; m_pc_d = m_pc; m_pc4_d = m_pc + 32'd4; m_valid = 1;
        m_cnt = m_cnt + 32'd1;
      end
      m_pc = target;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] cnt_hold;
    n_chk = 0; n_bad = 0;
    reset = 1; stall = 0; clr_d = 0; npc_sel = 0;
    br_target = 0; j_index = 0; jr_target = 0; instr_in = 0;
    m_pc = 0; m_instr_d = 0; m_pc_d = 0; m_pc4_d = 0; m_valid = 0; m_cnt = 0;

    // Reset (asserted together with stall/clr/redirect to confirm it dominates).
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 32'h4000, 0, 0, 32'hDEAD_BEEF);
    chk("reset_pc", pc_out, 32'h3000);

    // Three free-running fetches.
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h1111_1111);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h2222_2222);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h3333_3333);
    chk("seq_pc", pc_out, 32'h300C);
    chk("seq_pc_d", pc_d, 32'h3008);
    chk("seq_instr", instr_d, 32'h3333_3333);
    chk("seq_cnt", fetch_cnt, 32'd3);

    // Branch; the delay-slot fetch at 0x300C is latched normally.
    cyc(0, 0, 0, 1, 32'h3040, 0, 0, 32'h4444_4444);
    chk("br_pc", pc_out, 32'h3040);
    chk("br_slot_pc_d", pc_d, 32'h300C);

    // Jump uses pc4_d region (0x3010 -> region 0).
    cyc(0, 0, 0, 2, 0, 26'h0000C20, 0, 32'h5555_5555);
    chk("j_pc", pc_out, 32'h3080);
    // jr with unaligned target is silently aligned.
    cyc(0, 0, 0, 3, 0, 0, 32'h0000_3043, 32'h6666_6666);
    chk("jr_pc", pc_out, 32'h3040);

    // Stall two cycles with a pending redirect: everything holds.
    cnt_hold = m_cnt;
    cyc(0, 1, 0, 1, 32'h4000, 0, 0, 32'h7777_7777);
    cyc(0, 1, 0, 1, 32'h4000, 0, 0, 32'h7777_7777);
    chk("stall_pc", pc_out, 32'h3040);
    chk("stall_cnt", fetch_cnt, cnt_hold);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h8888_8888);
    chk("unstall_pc", pc_out, 32'h3044);

    // Clear D: bubble, counter holds, PC advances.
    cnt_hold = m_cnt;
    cyc(0, 0, 1, 0, 0, 0, 0, 32'h9999_9999);
    chk("clr_instr", instr_d, 32'h0);
    chk("clr_cnt", fetch_cnt, cnt_hold);
    chk("clr_pc", pc_out, 32'h3048);
    // Stall beats clear.
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hAAAA_AAAA);
    cyc(0, 1, 1, 0, 0, 0, 0, 32'hBBBB_BBBB);
    chk("stallclr_valid", {31'd0, valid_d}, 32'd1);

    // PC wraps through the +4 adder.
    cyc(0, 0, 0, 3, 0, 0, 32'hFFFF_FFFE, 32'hCCCC_CCCC);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hDDDD_DDDD);
    chk("wrap_pc", pc_out, 32'h0);

    // Mid-run reset while stalled.
    cyc(0, 0, 0, 1, 32'h3040, 0, 0, 32'h1234_5678);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("midreset_pc", pc_out, 32'h3000);
    chk("midreset_cnt", fetch_cnt, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          2'($urandom_range(3)), $urandom, 26'($urandom), $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
